// File: rtl/sig_monitor.sv
// sig_monitor: watches data-memory word stores for three magic addresses.
// Stores to SIG_ADDR are queued in a first-word-fall-through signature FIFO,
// stores to HALT_ADDR / TOHOST_ADDR (or an optional RUN-state timeout) end the
// run. The monitor then drains the FIFO and parks in DONE until reset.
module sig_monitor #(
    parameter int unsigned            ADDR_W      = 32,
    parameter int unsigned            DATA_W      = 32,
    parameter logic [ADDR_W-1:0]      SIG_ADDR    = 32'h8E000000,
    parameter logic [ADDR_W-1:0]      HALT_ADDR   = 32'h8F000000,
    parameter logic [ADDR_W-1:0]      TOHOST_ADDR = 32'h80001000,
    parameter int unsigned            FIFO_DEPTH  = 16,
    parameter int unsigned            TIMEOUT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_dmem_addr,
    input  logic [DATA_W-1:0] i_dmem_wdata,
    input  logic [1:0]        i_dmem_wr_type,
    output logic              o_sig_valid,
    output logic [DATA_W-1:0] o_sig_data,
    input  logic              i_sig_ready,
    output logic [15:0]       o_sig_count,
    output logic              o_overflow,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_fail,
    output logic              o_timeout,
    output logic [DATA_W-1:0] o_exit_code
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [15:0]       sig_count_q, sig_count_d;
    logic              overflow_q, overflow_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] exit_code_q, exit_code_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;

    logic wr_word;
    logic hit_sig;
    logic hit_halt;
    logic hit_tohost;
    logic in_run;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push_req;
    logic push;
    logic drop;
    logic tmo_hit;

    // Address decode, FIFO handshake and timeout terminal-count detection.
    always_comb begin
        wr_word    = (i_dmem_wr_type == 2'b11);
        hit_sig    = wr_word && (i_dmem_addr == SIG_ADDR);
        hit_halt   = wr_word && (i_dmem_addr == HALT_ADDR);
        hit_tohost = wr_word && (i_dmem_addr == TOHOST_ADDR);
        in_run     = (state_q == ST_RUN);
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
        pop        = !fifo_empty && i_sig_ready;
        push_req   = in_run && hit_sig;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
        tmo_hit    = (TIMEOUT != 0) && (tmo_cnt_q == 32'(TIMEOUT - 1));
    end

    // FIFO pointer/occupancy update and signature statistics.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        sig_count_d = sig_count_q;
        overflow_d  = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (sig_count_q != '1) begin
                sig_count_d = sig_count_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Run-control FSM: termination cause, exit code and timeout counter.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        exit_code_d = exit_code_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (TIMEOUT != 0) begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
                if (hit_tohost) begin
                    exit_code_d = i_dmem_wdata;
                    pass_d      = (i_dmem_wdata == DATA_W'(1));
                    fail_d      = (i_dmem_wdata != DATA_W'(1));
                    state_d     = ST_DRAIN;
                end else if (hit_halt) begin
                    state_d = ST_DRAIN;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            sig_count_q <= '0;
            overflow_q  <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            exit_code_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            sig_count_q <= sig_count_d;
            overflow_q  <= overflow_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            exit_code_q <= exit_code_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Signature storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= i_dmem_wdata;
        end
    end

    // Output mapping.
    always_comb begin
        o_sig_valid = !fifo_empty;
        o_sig_data  = mem_q[rd_ptr_q];
        o_sig_count = sig_count_q;
        o_overflow  = overflow_q;
        o_done      = (state_q == ST_DONE);
        o_pass      = pass_q;
        o_fail      = fail_q;
        o_timeout   = timeout_q;
        o_exit_code = exit_code_q;
    end

endmodule

// File: tb/tb_sig_monitor.sv
// Scoreboard bench for sig_monitor (FIFO_DEPTH=4, TIMEOUT=100).
module tb_sig_monitor;

    localparam logic [31:0] SIG    = 32'h8E000000;
    localparam logic [31:0] HALT   = 32'h8F000000;
    localparam logic [31:0] TOHOST = 32'h80001000;

    logic        clk;
    logic        rst;
    logic [31:0] i_dmem_addr;
    logic [31:0] i_dmem_wdata;
    logic [1:0]  i_dmem_wr_type;
    logic        o_sig_valid;
    logic [31:0] o_sig_data;
    logic        i_sig_ready;
    logic [15:0] o_sig_count;
    logic        o_overflow;
    logic        o_done;
    logic        o_pass;
    logic        o_fail;
    logic        o_timeout;
    logic [31:0] o_exit_code;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    sig_monitor #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .SIG_ADDR    (SIG),
        .HALT_ADDR   (HALT),
        .TOHOST_ADDR (TOHOST),
        .FIFO_DEPTH  (4),
        .TIMEOUT     (100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_dmem_addr    (i_dmem_addr),
        .i_dmem_wdata   (i_dmem_wdata),
        .i_dmem_wr_type (i_dmem_wr_type),
        .o_sig_valid    (o_sig_valid),
        .o_sig_data     (o_sig_data),
        .i_sig_ready    (i_sig_ready),
        .o_sig_count    (o_sig_count),
        .o_overflow     (o_overflow),
        .o_done         (o_done),
        .o_pass         (o_pass),
        .o_fail         (o_fail),
        .o_timeout      (o_timeout),
        .o_exit_code    (o_exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pops expected words whenever the DUT will hand one over on the next edge.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!rst && o_sig_valid && i_sig_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got %0h expected none", o_sig_data);
                end else begin
                    check("sig_data", o_sig_data, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        i_sig_ready    = 1'b0;
        i_dmem_wr_type = 2'b00;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        i_dmem_addr    = addr;
        i_dmem_wdata   = data;
        i_dmem_wr_type = 2'b11;
        @(posedge clk);
        #1;
        i_dmem_wr_type = 2'b00;
        i_dmem_addr    = '0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_valid"},   {31'd0, o_sig_valid}, 32'd0);
        check({tag, "_count"},   {16'd0, o_sig_count}, 32'd0);
        check({tag, "_ovf"},     {31'd0, o_overflow},  32'd0);
        check({tag, "_done"},    {31'd0, o_done},      32'd0);
        check({tag, "_pass"},    {31'd0, o_pass},      32'd0);
        check({tag, "_fail"},    {31'd0, o_fail},      32'd0);
        check({tag, "_timeout"}, {31'd0, o_timeout},   32'd0);
        check({tag, "_exit"},    o_exit_code,          32'd0);
    endtask

    initial begin
        logic [31:0] vec [6];
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        i_sig_ready    = 1'b0;
        i_dmem_addr    = '0;
        i_dmem_wdata   = '0;
        i_dmem_wr_type = 2'b00;
        fork
            monitor_loop();
        join_none

        // Reset state
        do_reset();
        check_reset_state("rst0");

        // Three signature words streamed straight out
        i_sig_ready = 1'b1;
        vec[0] = 32'hA; vec[1] = 32'hB; vec[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(vec[i]);
            wr(SIG, vec[i]);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t1_count", {16'd0, o_sig_count}, 32'd3);
        check("t1_ovf", {31'd0, o_overflow}, 32'd0);
        check("t1_drained", exp_q.size(), 32'd0);
        check("t1_valid", {31'd0, o_sig_valid}, 32'd0);
        check("t1_done", {31'd0, o_done}, 32'd0);

        // Overflow with depth 4, then push on full with simultaneous pop
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(32'(i + 1));
            wr(SIG, 32'(i + 1));
        end
        @(negedge clk);
        check("t2_count", {16'd0, o_sig_count}, 32'd4);
        check("t2_ovf", {31'd0, o_overflow}, 32'd1);
        check("t2_valid", {31'd0, o_sig_valid}, 32'd1);
        check("t2_head", o_sig_data, 32'd1);
        @(posedge clk);
        #1;
        i_sig_ready = 1'b1;
        exp_q.push_back(32'd7);
        wr(SIG, 32'd7);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t2_count_full_pop", {16'd0, o_sig_count}, 32'd5);
        check("t2_ovf_sticky", {31'd0, o_overflow}, 32'd1);
        check("t2_drained", exp_q.size(), 32'd0);

        // Halt with buffered words, drain, then DONE
        do_reset();
        exp_q.push_back(32'h11);
        wr(SIG, 32'h11);
        exp_q.push_back(32'h22);
        wr(SIG, 32'h22);
        wr(HALT, 32'h0);
        @(negedge clk);
        check("t3_done_drain", {31'd0, o_done}, 32'd0);
        check("t3_valid_drain", {31'd0, o_sig_valid}, 32'd1);
        check("t3_pass_halt", {31'd0, o_pass}, 32'd0);
        check("t3_fail_halt", {31'd0, o_fail}, 32'd0);
        wr(SIG, 32'h99);
        i_sig_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_done_early", {31'd0, o_done}, 32'd0);
        check("t3_valid_empty", {31'd0, o_sig_valid}, 32'd0);
        @(negedge clk);
        check("t3_done", {31'd0, o_done}, 32'd1);
        check("t3_drained", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
        wr(SIG, 32'h55);
        @(negedge clk);
        check("t3_count_ignored", {16'd0, o_sig_count}, 32'd2);
        check("t3_valid_ignored", {31'd0, o_sig_valid}, 32'd0);

        // Tohost pass
        do_reset();
        wr(TOHOST, 32'd1);
        @(negedge clk);
        check("t4_pass", {31'd0, o_pass}, 32'd1);
        check("t4_fail", {31'd0, o_fail}, 32'd0);
        check("t4_exit", o_exit_code, 32'd1);
        check("t4_done_early", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        check("t4_done", {31'd0, o_done}, 32'd1);
        @(posedge clk);
        #1;
        wr(TOHOST, 32'd5);
        @(negedge clk);
        check("t4_exit_held", o_exit_code, 32'd1);
        check("t4_fail_held", {31'd0, o_fail}, 32'd0);

        // Tohost fail
        do_reset();
        wr(TOHOST, 32'd7);
        @(negedge clk);
        check("t5_fail", {31'd0, o_fail}, 32'd1);
        check("t5_pass", {31'd0, o_pass}, 32'd0);
        check("t5_exit", o_exit_code, 32'd7);

        // Tohost on the timeout cycle wins
        do_reset();
        repeat (99) @(posedge clk);
        #1;
        wr(TOHOST, 32'd3);
        @(negedge clk);
        check("t6_fail", {31'd0, o_fail}, 32'd1);
        check("t6_timeout", {31'd0, o_timeout}, 32'd0);
        check("t6_exit", o_exit_code, 32'd3);

        // Timeout after 100 RUN cycles, then reset clears everything
        do_reset();
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("t7_timeout_early", {31'd0, o_timeout}, 32'd0);
        @(negedge clk);
        check("t7_timeout", {31'd0, o_timeout}, 32'd1);
        check("t7_done_drain", {31'd0, o_done}, 32'd0);
        check("t7_pass", {31'd0, o_pass}, 32'd0);
        check("t7_fail", {31'd0, o_fail}, 32'd0);
        @(negedge clk);
        check("t7_done", {31'd0, o_done}, 32'd1);
        do_reset();
        check_reset_state("t7_rst");

        // Reset in the middle of DRAIN discards buffered words
        i_sig_ready = 1'b0;
        wr(SIG, 32'h31);
        wr(SIG, 32'h32);
        wr(HALT, 32'h0);
        do_reset();
        check_reset_state("t8_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sig_monitor.md
SIG_MONITOR -- requirements
Module: sig_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, dmem address width.
REQ-002 SHALL have parameter DATA_W, default 32, dmem write-data width.
REQ-003 SHALL have parameter SIG_ADDR, default 32'h8E000000, signature-port address.
REQ-004 SHALL have parameter HALT_ADDR, default 32'h8F000000, halt-port address.
REQ-005 SHALL have parameter TOHOST_ADDR, default 32'h80001000, pass/fail-port address.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, signature FIFO entries; power of two, >=2.
REQ-007 SHALL have parameter TIMEOUT, default 0, RUN-state cycle limit; 0 disables the timeout.
REQ-008 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port i_dmem_addr, input, ADDR_W, store address.
REQ-011 SHALL have port i_dmem_wdata, input, DATA_W, store data.
REQ-012 SHALL have port i_dmem_wr_type, input, 2, store type; 2'b11 = word store; other values are not monitored.
REQ-013 SHALL have port o_sig_valid, input-side handshake output, 1, FIFO head valid.
REQ-014 SHALL have port o_sig_data, output, DATA_W, FIFO head word.
REQ-015 SHALL have port i_sig_ready, input, 1, consumer pops head when o_sig_valid & i_sig_ready.
REQ-016 SHALL have port o_sig_count, output, 16, signature words accepted, saturating at 16'hFFFF.
REQ-017 SHALL have port o_overflow, output, 1, sticky: a signature word was dropped.
REQ-018 SHALL have port o_done, output, 1, monitor has reached DONE.
REQ-019 SHALL have port o_pass, output, 1, tohost reported pass.
REQ-020 SHALL have port o_fail, output, 1, tohost reported fail.
REQ-021 SHALL have port o_timeout, output, 1, TIMEOUT expired.
REQ-022 SHALL have port o_exit_code, output, DATA_W, last tohost wdata.

Function
REQ-023 SHALL define the monitored event "hit X" as i_dmem_wr_type==2'b11 & i_dmem_addr==X, sampled on the clk edge.
REQ-024 SHALL implement states RUN, DRAIN, DONE; it leaves reset in RUN.
REQ-025 In RUN, a hit SIG_ADDR SHALL push i_dmem_wdata into the FIFO and increment o_sig_count; the word appears at o_sig_data with o_sig_valid=1 on the next cycle at the earliest.
REQ-026 A push with the FIFO full and no pop the same cycle SHALL drop the word, set o_overflow, and leave o_sig_count unchanged; a push with full FIFO and simultaneous pop SHALL be accepted.
REQ-027 The FIFO SHALL be first-word-fall-through, order-preserving, with pointers wrapping modulo FIFO_DEPTH; a pop with empty FIFO SHALL have no effect.
REQ-028 In RUN, a hit HALT_ADDR SHALL move to DRAIN next cycle; o_pass/o_fail stay 0.
REQ-029 In RUN, a hit TOHOST_ADDR SHALL latch o_exit_code=wdata, set o_pass if wdata==1 else o_fail, and move to DRAIN.
REQ-030 If TIMEOUT!=0, a cycle counter SHALL run only in RUN; in the cycle the count reaches TIMEOUT-1 without a halt/tohost hit, set o_timeout and move to DRAIN.
REQ-031 Priority in RUN on the same cycle: TOHOST hit > HALT hit > timeout; a SIG hit is impossible on the same address; at most one terminating cause is recorded.
REQ-032 In DRAIN, all hits SHALL be ignored; popping continues; when the FIFO is empty the state SHALL move to DONE next cycle.
REQ-033 In DONE, o_done=1, all hits ignored, all flags held until rst; popping of residual data remains legal (FIFO is empty).
REQ-034 o_pass, o_fail and o_timeout SHALL be mutually exclusive.

Reset
REQ-035 rst SHALL, in the cycle sampled, set state RUN, empty the FIFO, and clear o_sig_valid, o_sig_count, o_overflow, o_done, o_pass, o_fail, o_timeout, o_exit_code and the timeout counter to 0; o_sig_data is don't-care when o_sig_valid=0.
REQ-036 rst asserted mid-DRAIN or mid-RUN SHALL discard all buffered words and flags with no partial state surviving.

Verification
REQ-037 Three SIG hits 0xA,0xB,0xC, i_sig_ready=1 -> o_sig_data 0xA,0xB,0xC in order, o_sig_count=3, o_overflow=0.
REQ-038 FIFO_DEPTH=4, i_sig_ready=0, six SIG hits -> four words retained, o_overflow=1, o_sig_count=4; push with full+pop same cycle -> accepted.
REQ-039 Two words buffered, HALT hit, i_sig_ready=0 -> DRAIN, o_done=0; raise ready -> both popped, o_done=1 two cycles after last pop-empty; later SIG hits ignored.
REQ-040 TOHOST wdata=1 -> o_pass=1,o_exit_code=1; separate run TOHOST wdata=0x7 -> o_fail=1,o_exit_code=7; TOHOST and timeout same cycle -> o_timeout=0.
REQ-041 TIMEOUT=100, no hits -> o_timeout=1, state DRAIN after 100 RUN cycles, o_done=1 next cycle; rst then -> all outputs 0, state RUN.
